// File: rtl/isa_dma_channel.sv
// ---------------------------------------------------------------------------
// isa_dma_channel
//   Single-channel, 8237-style ISA DMA engine. Requests the bus from the CPU,
//   moves one byte per device request between I/O and memory using 20-bit
//   {page, offset} addressing, flags terminal count on the last byte and then
//   either reloads (autoinit) or masks itself.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   cfg_addr/we/re       byte-wide register port (select, write, read strobes)
//   cfg_wdata/cfg_rdata  register write data / combinational read data
//   dreq, dack_n         device request / acknowledge (active low)
//   bus_req, bus_gnt     bus hold request / grant
//   aen, a_out, a_oe     bus ownership, 20-bit address, address drive enable
//   memr_n, memw_n       memory command strobes (active low)
//   ior_n, iow_n         I/O command strobes (active low)
//   tc                   terminal count, high in the release cycle of last byte
// ---------------------------------------------------------------------------
module isa_dma_channel #(
  parameter int STROBE_CYC  = 2,     // strobe low time per byte, 1..15
  parameter bit AUTOINIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cfg_addr,
  input  logic        cfg_we,
  input  logic        cfg_re,
  input  logic [7:0]  cfg_wdata,
  output logic [7:0]  cfg_rdata,
  input  logic        dreq,
  output logic        dack_n,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        aen,
  output logic [19:0] a_out,
  output logic        a_oe,
  output logic        memr_n,
  output logic        memw_n,
  output logic        ior_n,
  output logic        iow_n,
  output logic        tc
);

  typedef enum logic [2:0] {IDLE, HOLD, S1, S2, S3, S4} state_e;

  state_e      state_q;
  logic [3:0]  strb_cnt_q;      // strobe cycles left, including the current one
  logic [15:0] base_addr_q, cur_addr_q;
  logic [15:0] base_cnt_q, cur_cnt_q;
  logic [3:0]  page_q;
  logic        dir_q, autoinit_q, mask_q, tc_reached_q, ff_q;
  logic        dack_n_q, bus_req_q, aen_q, a_oe_q, tc_q;
  logic        memr_n_q, memw_n_q, ior_n_q, iow_n_q;
  logic [19:0] a_out_q;

  logic last_strobe, tc_hit, status_rd, busy;

  assign last_strobe = ((state_q == S2) || (state_q == S3)) && (strb_cnt_q == 4'd1);
  assign tc_hit      = last_strobe && (cur_cnt_q == 16'd0);
  assign status_rd   = cfg_re && (cfg_addr == 3'd6);
  assign busy        = (state_q != IDLE);

  // NOTE: every branch of cfg_rdata is covered by the default assignment
  // first, so no latch can be inferred for an unlisted register select.
  always_comb begin
    cfg_rdata = 8'h00;
    unique case (cfg_addr)
      3'd0:    cfg_rdata = ff_q ? cur_addr_q[15:8] : cur_addr_q[7:0];
      3'd1:    cfg_rdata = ff_q ? cur_cnt_q[15:8]  : cur_cnt_q[7:0];
      3'd2:    cfg_rdata = {4'h0, page_q};
      3'd3:    cfg_rdata = {6'h00, autoinit_q, dir_q};
      3'd4:    cfg_rdata = {7'h00, mask_q};
      3'd6:    cfg_rdata = {5'h00, mask_q, busy, tc_reached_q};
      default: cfg_rdata = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; where two
  // assignments to the same register fire in one cycle, the later one in this
  // block wins, which is how register-port writes override the transfer
  // engine's own updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      strb_cnt_q   <= 4'd0;
      base_addr_q  <= 16'h0000;
      cur_addr_q   <= 16'h0000;
      base_cnt_q   <= 16'h0000;
      cur_cnt_q    <= 16'h0000;
      page_q       <= 4'h0;
      dir_q        <= 1'b0;
      autoinit_q   <= 1'b0;
      mask_q       <= 1'b1;
      tc_reached_q <= 1'b0;
      ff_q         <= 1'b0;
      dack_n_q     <= 1'b1;
      bus_req_q    <= 1'b0;
      aen_q        <= 1'b0;
      a_oe_q       <= 1'b0;
      tc_q         <= 1'b0;
      memr_n_q     <= 1'b1;
      memw_n_q     <= 1'b1;
      ior_n_q      <= 1'b1;
      iow_n_q      <= 1'b1;
      a_out_q      <= 20'h00000;
    end else begin
      // ---------------- transfer engine ----------------
      unique case (state_q)
        IDLE: if (dreq && !mask_q) begin
          state_q   <= HOLD;
          bus_req_q <= 1'b1;
        end
        HOLD: begin
          if (!dreq || mask_q) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
          end else if (bus_gnt) begin
            state_q  <= S1;
            aen_q    <= 1'b1;
            a_oe_q   <= 1'b1;
            dack_n_q <= 1'b0;
            a_out_q  <= {page_q, cur_addr_q};   // frozen for the whole byte
          end
        end
        S1: begin
          state_q    <= S2;
          strb_cnt_q <= 4'(STROBE_CYC);
          memw_n_q   <= dir_q;
          ior_n_q    <= dir_q;
          memr_n_q   <= !dir_q;
          iow_n_q    <= !dir_q;
        end
        S2, S3: begin
          if (last_strobe) begin
            state_q    <= S4;
            memr_n_q   <= 1'b1;
            memw_n_q   <= 1'b1;
            ior_n_q    <= 1'b1;
            iow_n_q    <= 1'b1;
            tc_q       <= tc_hit;
            cur_addr_q <= cur_addr_q + 16'd1;   // 16-bit wrap, page untouched
            cur_cnt_q  <= cur_cnt_q - 16'd1;
            if (tc_hit) begin
              tc_reached_q <= 1'b1;
              if (autoinit_q) begin
                cur_addr_q <= base_addr_q;
                cur_cnt_q  <= base_cnt_q;
              end else begin
                mask_q <= 1'b1;
              end
            end
          end else begin
            state_q    <= S3;
            strb_cnt_q <= strb_cnt_q - 4'd1;
          end
        end
        S4: begin
          state_q   <= IDLE;
          tc_q      <= 1'b0;
          dack_n_q  <= 1'b1;
          aen_q     <= 1'b0;
          a_oe_q    <= 1'b0;
          bus_req_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase

      // ---------------- register port ----------------
      if (cfg_we) begin
        unique case (cfg_addr)
          3'd0: begin
            if (ff_q) begin
              base_addr_q[15:8] <= cfg_wdata;
              cur_addr_q[15:8]  <= cfg_wdata;
            end else begin
              base_addr_q[7:0] <= cfg_wdata;
              cur_addr_q[7:0]  <= cfg_wdata;
            end
          end
          3'd1: begin
            if (ff_q) begin
              base_cnt_q[15:8] <= cfg_wdata;
              cur_cnt_q[15:8]  <= cfg_wdata;
            end else begin
              base_cnt_q[7:0] <= cfg_wdata;
              cur_cnt_q[7:0]  <= cfg_wdata;
            end
          end
          3'd2: page_q <= cfg_wdata[3:0];
          3'd3: begin
            dir_q      <= cfg_wdata[0];
            autoinit_q <= cfg_wdata[1] & AUTOINIT_EN;
          end
          3'd4:    mask_q <= cfg_wdata[0];
          default: ;
        endcase
      end

      // Byte-pointer flip-flop shared by the address and count registers.
      if (cfg_we && (cfg_addr == 3'd0 || cfg_addr == 3'd1)) begin
        ff_q <= !ff_q;
      end else if (cfg_we && cfg_addr == 3'd5) begin
        ff_q <= 1'b0;
      end else if (cfg_re && (cfg_addr == 3'd0 || cfg_addr == 3'd1)) begin
        ff_q <= !ff_q;
      end

      // A status read clears TC-reached unless a new TC lands in the same cycle.
      if (status_rd && !tc_hit) tc_reached_q <= 1'b0;
    end
  end

  assign dack_n  = dack_n_q;
  assign bus_req = bus_req_q;
  assign aen     = aen_q;
  assign a_out   = a_out_q;
  assign a_oe    = a_oe_q;
  assign memr_n  = memr_n_q;
  assign memw_n  = memw_n_q;
  assign ior_n   = ior_n_q;
  assign iow_n   = iow_n_q;
  assign tc      = tc_q;

endmodule

// File: tb/tb_isa_dma_channel.sv
// ---------------------------------------------------------------------------
// tb_isa_dma_channel
//   Self-checking bench for isa_dma_channel. Each scenario programs the
//   channel and pushes the bytes it must produce (address, direction, tc,
//   abort) into an expectation queue computed from the count/address rules.
//   A bus monitor watches every cycle and matches each observed byte against
//   that queue; directed register reads pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_isa_dma_channel;

  localparam int STROBE_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cfg_addr;
  logic        cfg_we, cfg_re;
  logic [7:0]  cfg_wdata, cfg_rdata;
  logic        dreq, dack_n, bus_req, bus_gnt, aen, a_oe;
  logic [19:0] a_out;
  logic        memr_n, memw_n, ior_n, iow_n, tc;

  always #5 clk = ~clk;

  isa_dma_channel #(.STROBE_CYC(STROBE_CYC), .AUTOINIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cfg_addr(cfg_addr), .cfg_we(cfg_we), .cfg_re(cfg_re),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .dreq(dreq), .dack_n(dack_n), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .aen(aen), .a_out(a_out), .a_oe(a_oe),
    .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n), .tc(tc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: expected bytes ----------------
  typedef struct {
    logic [19:0] addr;
    logic        dir;
    logic        tc;
    logic        aborted;
  } exp_t;

  exp_t exp_q[$];

  // n bytes of a block starting at addr with programmed count cnt.
  task automatic push_block(input logic [3:0] page, input logic [15:0] addr,
                            input logic [15:0] cnt, input logic dir, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr    = {page, 16'(addr + 16'(i))};
      e.dir     = dir;
      e.tc      = (16'(cnt - 16'(i)) == 16'd0);
      e.aborted = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // ---------------- bus monitor / compare process ----------------
  int          run_len  = 0;
  logic [19:0] run_addr;
  logic [3:0]  run_strb;
  logic        post_rel = 1'b0;
  logic        any_low;
  exp_t        cur_e;

  always @(negedge clk) begin
    any_low = !(memr_n && memw_n && ior_n && iow_n);
    if (post_rel) begin
      check("release_idle", {dack_n, aen, a_oe, bus_req}, 4'b1000);
      post_rel = 1'b0;
    end
    if (any_low) begin
      check("strobe_qual", {dack_n, aen, a_oe, tc}, 4'b0110);
      if (run_len == 0) begin
        run_addr = a_out;
        run_strb = {memr_n, memw_n, ior_n, iow_n};
      end
      run_len++;
    end else if (run_len != 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", run_addr, 32'hFFFFFFFF);
      end else begin
        cur_e = exp_q.pop_front();
        check("byte_addr", run_addr, cur_e.addr);
        check("byte_strobes", run_strb, cur_e.dir ? 4'b0110 : 4'b1001);
        if (cur_e.aborted) begin
          check("abort_dack", dack_n, 1'b1);
        end else begin
          check("strobe_len", run_len, STROBE_CYC);
          check("byte_tc", tc, cur_e.tc);
          check("release_dack", {dack_n, aen}, 2'b01);
          post_rel = 1'b1;
        end
      end
      run_len = 0;
    end else if (tc) begin
      check("tc_outside_release", tc, 1'b0);
    end
  end

  // ---------------- stimulus helpers (start/end at posedge+1) ----------------
  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cfg_addr = a; cfg_re = 1'b1;
    #1 d = cfg_rdata;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    check(name, d, exp);
  endtask

  task automatic wait_q_empty(input string name, input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    if (k == max_cyc) check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t ab;
    int   k;
    rst = 1'b1; cfg_addr = 3'd0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_wdata = 8'h00;
    dreq = 1'b0; bus_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    check("rst_outputs", {dack_n, memr_n, memw_n, ior_n, iow_n, bus_req, aen, a_oe, tc},
          9'b111110000);
    check("rst_a_out", a_out, 20'h00000);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_check("rst_page", 3'd2, 8'h00);
    rd_check("rst_mode", 3'd3, 8'h00);
    rd_check("rst_mask", 3'd4, 8'h01);
    rd_check("rst_status", 3'd6, 8'h04);
    rd_check("rst_addr_lo", 3'd0, 8'h00);
    rd_check("rst_addr_hi", 3'd0, 8'h00);

    // Test 1: page 2, addr 0x1000, count 2, device->memory, 3 bytes.
    cfg_write(3'd5, 8'h00);
    cfg_write(3'd2, 8'h02);
    cfg_write(3'd0, 8'h00); cfg_write(3'd0, 8'h10);
    cfg_write(3'd1, 8'h02); cfg_write(3'd1, 8'h00);
    cfg_write(3'd3, 8'h00);
    push_block(4'h2, 16'h1000, 16'h0002, 1'b0, 3);
    cfg_write(3'd4, 8'h00);
    dreq = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    wait_q_empty("t1_timeout", 100);
    repeat (10) @(posedge clk);
    #1;
    check("t1_masked_no_req", bus_req, 1'b0);
    dreq = 1'b0;
    rd_check("t1_mask", 3'd4, 8'h01);
    rd_check("t1_status", 3'd6, 8'h05);
    rd_check("t1_status_clr", 3'd6, 8'h04);
    rd_check("t1_addr_lo", 3'd0, 8'h03);
    rd_check("t1_addr_hi", 3'd0, 8'h10);
    rd_check("t1_cnt_lo", 3'd1, 8'hFF);
    rd_check("t1_cnt_hi", 3'd1, 8'hFF);

    // Test 2: offset wrap without page carry.
    cfg_write(3'd2, 8'h03);
    cfg_write(3'd0, 8'hFF); cfg_write(3'd0, 8'hFF);
    cfg_write(3'd1, 8'h01); cfg_write(3'd1, 8'h00);
    push_block(4'h3, 16'hFFFF, 16'h0001, 1'b0, 2);
    cfg_write(3'd4, 8'h00);
    dreq = 1'b1;
    wait_q_empty("t2_timeout", 100);
    dreq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd_check("t2_addr_lo", 3'd0, 8'h01);
    rd_check("t2_addr_hi", 3'd0, 8'h00);
    rd_check("t2_status", 3'd6, 8'h05);

    // Test 3: autoinit, addr 0x0040, count 0, two single requests.
    cfg_write(3'd2, 8'h00);
    cfg_write(3'd0, 8'h40); cfg_write(3'd0, 8'h00);
    cfg_write(3'd1, 8'h00); cfg_write(3'd1, 8'h00);
    cfg_write(3'd3, 8'h02);
    cfg_write(3'd4, 8'h00);
    for (int r = 0; r < 2; r++) begin
      push_block(4'h0, 16'h0040, 16'h0000, 1'b0, 1);
      dreq = 1'b1;
      wait_q_empty("t3_timeout", 50);
      dreq = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rd_check("t3_mask_stays", 3'd4, 8'h00);
    end
    rd_check("t3_status", 3'd6, 8'h01);
    rd_check("t3_status_clr", 3'd6, 8'h00);
    rd_check("t3_reload_lo", 3'd0, 8'h40);
    rd_check("t3_reload_hi", 3'd0, 8'h00);

    // Test 4: grant withheld, request withdrawn.
    bus_gnt = 1'b0;
    dreq = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t4_bus_req_up", {bus_req, dack_n, aen}, 3'b110);
    dreq = 1'b0;
    @(posedge clk); #1;
    check("t4_bus_req_down", {bus_req, dack_n, aen}, 3'b010);

    // Test 5: reset during the strobe phase, memory->device.
    cfg_write(3'd3, 8'h01);
    cfg_write(3'd2, 8'h01);
    cfg_write(3'd0, 8'h00); cfg_write(3'd0, 8'h02);
    cfg_write(3'd1, 8'h05); cfg_write(3'd1, 8'h00);
    ab.addr = 20'h10200; ab.dir = 1'b1; ab.tc = 1'b0; ab.aborted = 1'b1;
    exp_q.push_back(ab);
    cfg_write(3'd4, 8'h00);
    bus_gnt = 1'b1;
    dreq = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!memr_n) break;
    end
    if (k == 50) check("t5_timeout", 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_outputs", {memr_n, iow_n, dack_n, aen, a_oe, bus_req, tc}, 7'b1110000);
    rst = 1'b0; dreq = 1'b0; bus_gnt = 1'b0;
    rd_check("t5_page", 3'd2, 8'h00);
    rd_check("t5_mode", 3'd3, 8'h00);
    rd_check("t5_status", 3'd6, 8'h04);
    rd_check("t5_addr_lo", 3'd0, 8'h00);
    rd_check("t5_addr_hi", 3'd0, 8'h00);
    rd_check("t5_cnt_lo", 3'd1, 8'h00);
    rd_check("t5_cnt_hi", 3'd1, 8'h00);

    // Test 6: byte-pointer flip-flop.
    cfg_write(3'd5, 8'h00);
    cfg_write(3'd0, 8'h34);
    cfg_write(3'd0, 8'h12);
    cfg_write(3'd5, 8'h00);
    rd_check("t6_ff_lo", 3'd0, 8'h34);
    rd_check("t6_ff_hi", 3'd0, 8'h12);

    repeat (3) @(posedge clk);
    #1;
    check("exp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/isa_dma_channel.md
Name: isa_dma_channel

Overview:
- Single-channel, 8237-style ISA DMA engine. It is the host-side counterpart that services the floppy controller's drq2/dack2_n/tc handshake.
- It takes the bus from the CPU and moves one byte per request between I/O device and memory using 20-bit page+offset addressing.
- It asserts tc on the final byte and then either auto-reloads or masks itself.
- It is programmed through a small byte-wide register port decoded by the system I/O logic.

Parameters:
- STROBE_CYC, 2, cycles the command strobes are held low per byte (legal range 1..15).
- AUTOINIT_EN, 1, when 0 the mode autoinit bit is forced to 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- cfg_addr  input  3  register select.
- cfg_we  input  1  register write strobe, one cycle.
- cfg_re  input  1  register read strobe, one cycle.
- cfg_wdata  input  8  register write data.
- cfg_rdata  output  8  register read data, combinational from cfg_addr.
- dreq  input  1  device DMA request, active high.
- dack_n  output  1  DMA acknowledge to the device, active low.
- bus_req  output  1  bus hold request to the CPU arbiter.
- bus_gnt  input  1  bus hold grant.
- aen  output  1  high while the channel owns the bus.
- a_out  output  20  memory address, {page, current_addr}.
- a_oe  output  1  address drive enable.
- memr_n  output  1  memory read strobe.
- memw_n  output  1  memory write strobe.
- ior_n  output  1  I/O read strobe.
- iow_n  output  1  I/O write strobe.
- tc  output  1  terminal count, high for the strobe-release cycle of the last byte.

Behaviour:
- Registers:
  - 0 = address, written low byte then high byte via the byte-pointer flip-flop (FF).
  - 1 = count, same FF.
  - 2 = page[3:0].
  - 3 = mode: bit0 dir (0 = device->memory, 1 = memory->device), bit1 autoinit.
  - 4 = mask, bit0.
  - 5 = any write clears FF.
  - 6 = status read: bit0 TC-reached, bit1 busy, bit2 mask; reading clears TC-reached.
- Writes to address or count load both the base and current copies and toggle FF. Reads of regs 0/1 return current low/high via FF and toggle FF.
- Reset values:
  - Outputs: dack_n=1, all strobes=1, bus_req=0, aen=0, a_oe=0, tc=0, a_out=0.
  - Registers: all 0, FF=0, mask=1.
- FSM states: IDLE, HOLD, S1, S2, S3, S4.
  - IDLE: if dreq && !mask, go to HOLD and drive bus_req=1.
  - HOLD: if dreq=0 or mask=1, return to IDLE and drop bus_req. If bus_gnt=1, go to S1.
  - S1 (1 cycle): aen=1, a_oe=1, dack_n=0, a_out={page, current_addr}.
  - S2: assert strobes.
    - dir=0: ior_n=0 and memw_n=0.
    - dir=1: memr_n=0 and iow_n=0.
    - Hold strobes for STROBE_CYC cycles (S2 plus S3 counter), then go to S4.
  - S4 (1 cycle):
    - Strobes high; dack_n stays 0.
    - tc=1 if current_count==0.
    - current_addr increments, 16-bit wrap with page unchanged (0xFFFF -> 0x0000, no carry into page).
    - current_count decrements mod 2^16.
  - Next cycle: dack_n=1, aen=0, a_oe=0, bus_req=0, return to IDLE.
- Single-transfer mode only: the bus is released after every byte. Each byte costs 3+STROBE_CYC cycles from grant.
- Byte count is count+1. Count 0 transfers 1 byte; count 0xFFFF transfers 65536 bytes.
- On tc:
  - Set TC-reached.
  - If autoinit: reload current from base and keep mask=0.
  - Else: set mask=1.
- dreq deasserting after S1 does not abort; the byte completes.
- cfg writes during S1..S4 update registers immediately, but the in-flight byte uses the address latched in S1. If mask is set mid-byte, the byte completes and the next request is ignored.
- Simultaneous status read and tc-set in the same cycle: set wins.
- rst mid-transfer returns everything to reset values on the next edge; strobes rise immediately at that edge.

Test Plan:
- Program page=2, addr=0x1000, count=0x0002, mode dir=0, mask=0; hold dreq high with bus_gnt=1 after 1 cycle.
  - Expect 3 bytes at a_out 0x21000, 0x21001, 0x21002, each with ior_n/memw_n low for 2 cycles.
  - Expect tc only on the third byte, then mask=1 and status=0x05.
- addr=0xFFFF, page=3, count=1 -> bytes at 0x3FFFF then 0x30000 (no page carry).
- Autoinit, addr=0x0040, count=0:
  - Two requests -> both at 0x00040 with tc on each; mask stays 0.
  - Status read returns bit0=1, then 0 on the second read.
- dreq asserted, bus_gnt withheld, dreq dropped -> bus_req falls within 1 cycle, no strobes, no dack_n.
- rst asserted during S2 with dir=1 -> next cycle memr_n=iow_n=dack_n=1, aen=0, mask=1, all regs 0.
- FF check: write reg5, then 0x34, then 0x12 to reg0 -> reg0 reads return 0x34 then 0x12.
